// File: rtl/instrn_mem_writer_if.sv
// Word-write request and byte-write port bundle for instrn_mem_writer.
// Optional macro INSTRN_MEM_WRITER_STRB_EN adds the per-byte strobe wr_strb.
//
// Handshake: a request transfers on a rising edge where wr_valid and
// wr_ready are both high. wr_ready never depends on wr_valid. The requester
// holds wr_valid, wr_address, wr_data (and wr_strb) stable until that edge.
interface instrn_mem_writer_if #(
    parameter int ADDR_W = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_address;
    logic [31:0]       wr_data;
`ifdef INSTRN_MEM_WRITER_STRB_EN
    logic [3:0]        wr_strb;
`endif
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              done;
    logic              err;
    logic              busy;

`ifdef INSTRN_MEM_WRITER_STRB_EN
    modport master (
        output wr_valid, wr_address, wr_data, wr_strb,
        input  wr_ready, mem_we, mem_addr, mem_wdata, done, err, busy
    );
    modport slave (
        input  wr_valid, wr_address, wr_data, wr_strb,
        output wr_ready, mem_we, mem_addr, mem_wdata, done, err, busy
    );
`else
    modport master (
        output wr_valid, wr_address, wr_data,
        input  wr_ready, mem_we, mem_addr, mem_wdata, done, err, busy
    );
    modport slave (
        input  wr_valid, wr_address, wr_data,
        output wr_ready, mem_we, mem_addr, mem_wdata, done, err, busy
    );
`endif
endinterface

// File: rtl/instrn_mem_writer.sv
// instrn_mem_writer: accepts 32-bit word writes and serialises each word into
// four little-endian byte writes (lowest byte at lowest address) for the
// byte-wide instruction memory. Misaligned or out-of-range words are rejected
// with a one-cycle err pulse and touch no byte.
// Optional macro INSTRN_MEM_WRITER_STRB_EN: adds wr_strb[3:0]; byte k is only
// written when wr_strb[k] is set, sequencing and timing are unchanged.
// dbg_state exposes the FSM state (0 IDLE, 1 WRITE, 2 ERROR).
module instrn_mem_writer #(
    parameter int MEM_BYTES = 36,
    parameter int ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    instrn_mem_writer_if.slave    bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    // Last legal byte address, widened by one bit so that a word address
    // near the top of the address space cannot wrap into range.
    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);
    localparam logic [ADDR_W:0] WORD_SPAN = (ADDR_W+1)'(3);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
`ifdef INSTRN_MEM_WRITER_STRB_EN
    logic [3:0]        strb_q, strb_d;
`endif

    logic [ADDR_W:0]   end_addr;
    logic              req_legal;
    logic              accept;

    // Request legality and acceptance, evaluated against the live inputs.
    always_comb begin
        end_addr  = {1'b0, bus.wr_address} + WORD_SPAN;
        req_legal = (bus.wr_address[1:0] == 2'b00) && (end_addr <= LAST_BYTE);
        accept    = bus.wr_valid && (state_q == S_IDLE);
    end

    // Next-state logic. addr_q/data_q always hold the byte being written, so
    // they also hold the last written byte once the FSM is back in IDLE.
    // Rejected requests do not disturb them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef INSTRN_MEM_WRITER_STRB_EN
        strb_d  = strb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_legal) begin
                        state_d = S_WRITE;
                        cnt_d   = 2'd0;
                        addr_d  = bus.wr_address;
                        data_d  = bus.wr_data;
`ifdef INSTRN_MEM_WRITER_STRB_EN
                        strb_d  = bus.wr_strb;
`endif
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == 2'd3) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d  = cnt_q + 2'd1;
                    addr_d = addr_q + ADDR_W'(1);
                    data_d = {8'h00, data_q[31:8]};
                end
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef INSTRN_MEM_WRITER_STRB_EN
            strb_q  <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef INSTRN_MEM_WRITER_STRB_EN
            strb_q  <= strb_d;
`endif
        end
    end

    // Outputs decoded from registered state only; done and err come from
    // different states, so they can never overlap.
    always_comb begin
        bus.wr_ready  = (state_q == S_IDLE);
        bus.busy      = (state_q != S_IDLE);
        bus.err       = (state_q == S_ERROR);
        bus.done      = (state_q == S_WRITE) && (cnt_q == 2'd3);
`ifdef INSTRN_MEM_WRITER_STRB_EN
        bus.mem_we    = (state_q == S_WRITE) && strb_q[cnt_q];
`else
        bus.mem_we    = (state_q == S_WRITE);
`endif
        bus.mem_addr  = addr_q;
        bus.mem_wdata = data_q[7:0];
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_instrn_mem_writer.sv
// Testbench for instrn_mem_writer: table of word requests with hand-computed
// byte sequences, plus hand-written back-to-back and reset corner sequences.
module tb_instrn_mem_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    instrn_mem_writer_if #(.ADDR_W(32)) bus ();

    instrn_mem_writer #(.MEM_BYTES(36), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Scoreboard of expected byte writes: {addr[31:0], byte[7:0]}.
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;

    logic [31:0] last_addr;
    logic [7:0]  last_byte;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_err;
        logic [31:0] exp_seq;   // bytes in write order, first byte in [31:24]
    } vec_t;

    vec_t vecs[10];
    int   n_vec;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-write monitor and pulse counters.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1) err_cnt++;
        if (bus.done === 1'b1 && bus.err === 1'b1) check("done_err_overlap", 40'd1, 40'd0);
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("byte_write", {bus.mem_addr, bus.mem_wdata}, mon_e);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.wr_valid   = 1'b1;
        bus.wr_address = addr;
        bus.wr_data    = data;
`ifdef INSTRN_MEM_WRITER_STRB_EN
        bus.wr_strb    = strb;
`else
        if (strb != 4'hF) $display("note: strobe ignored in this build");
`endif
    endtask

    task automatic idle_inputs();
        bus.wr_valid   = 1'b0;
        bus.wr_address = $urandom;
        bus.wr_data    = $urandom;
`ifdef INSTRN_MEM_WRITER_STRB_EN
        bus.wr_strb    = 4'($urandom_range(0, 15));
`endif
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_vec(input vec_t v);
        int wait_cyc;
        drive_req(v.addr, v.data, v.strb);
        wait_cyc = 0;
        while (!bus.wr_ready && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        if (!bus.wr_ready) begin
            check("ready_timeout", 40'd0, 40'd1);
            idle_inputs();
            return;
        end
        if (!v.exp_err) begin
            for (int k = 0; k < 4; k++)
                if (v.strb[k]) exp_q.push_back({v.addr + 32'(k), v.exp_seq[31-8*k -: 8]});
        end
        @(posedge clk); #1;   // acceptance edge N
        idle_inputs();        // later input changes must not affect the word
        if (v.exp_err) begin
            @(negedge clk);
            check("err_pulse", bus.err, 1);
            check("err_no_we", bus.mem_we, 0);
            check("err_no_done", bus.done, 0);
            check("err_ready_low", bus.wr_ready, 0);
            check("err_hold_addr", bus.mem_addr, last_addr);
            check("err_hold_wdata", bus.mem_wdata, last_byte);
            @(negedge clk);
            check("err_ready_back", bus.wr_ready, 1);
            check("err_cleared", bus.err, 0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("we", bus.mem_we, v.strb[k]);
                check("addr", bus.mem_addr, v.addr + 32'(k));
                check("wdata", bus.mem_wdata, v.exp_seq[31-8*k -: 8]);
                check("done", bus.done, (k == 3) ? 1 : 0);
                check("ready_low", bus.wr_ready, 0);
                check("busy", bus.busy, 1);
            end
            @(negedge clk);
            check("ready_back", bus.wr_ready, 1);
            check("done_cleared", bus.done, 0);
            check("idle_no_we", bus.mem_we, 0);
            check("hold_addr", bus.mem_addr, v.addr + 32'd3);
            check("hold_wdata", bus.mem_wdata, v.exp_seq[7:0]);
            last_addr = v.addr + 32'd3;
            last_byte = v.exp_seq[7:0];
        end
        @(posedge clk); #1;
    endtask

    int d0;

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h8C02_0004, 4'hF, 1'b0, 32'h0400_028C};
        vecs[1] = '{32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h4433_2211};
        vecs[2] = '{32'h0000_0024, 32'h5566_7788, 4'hF, 1'b1, 32'h0};
        vecs[3] = '{32'hFFFF_FFFC, 32'h99AA_BBCC, 4'hF, 1'b1, 32'h0};
        vecs[4] = '{32'h0000_0002, 32'h0102_0304, 4'hF, 1'b1, 32'h0};
        vecs[5] = '{32'h0000_001C, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'hEFBE_ADDE};
        vecs[6] = '{32'h0000_0021, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0};
        n_vec = 7;
`ifdef INSTRN_MEM_WRITER_STRB_EN
        vecs[7] = '{32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'hDDCC_BBAA};
        vecs[8] = '{32'h0000_001C, 32'h1234_5678, 4'b0000, 1'b0, 32'h7856_3412};
        n_vec = 9;
`endif

        // Reset
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.wr_ready, 1);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_addr = 32'h0;
        last_byte = 8'h0;

        // Table-driven vectors
        for (int i = 0; i < n_vec; i++) run_vec(vecs[i]);

        // Back-to-back: wr_valid held, second word accepted at N+5
        d0 = done_cnt;
        exp_q.push_back({32'd4, 8'h10});
        exp_q.push_back({32'd5, 8'h11});
        exp_q.push_back({32'd6, 8'h12});
        exp_q.push_back({32'd7, 8'h13});
        exp_q.push_back({32'd8, 8'h28});
        exp_q.push_back({32'd9, 8'h29});
        exp_q.push_back({32'd10, 8'h2A});
        exp_q.push_back({32'd11, 8'h2B});
        drive_req(32'h4, 32'h1312_1110, 4'hF);
        @(posedge clk); #1;   // edge N
        drive_req(32'h8, 32'h2B2A_2928, 4'hF);
        repeat (5) @(negedge clk);
        check("b2b_ready_n5", bus.wr_ready, 1);
        @(posedge clk); #1;   // edge N+5, second word accepted
        idle_inputs();
        @(negedge clk);
        check("b2b_second_busy", bus.busy, 1);
        repeat (5) @(negedge clk);
        check("b2b_done_pulses", 40'(done_cnt - d0), 40'd2);
        check("b2b_all_bytes", 40'(exp_q.size()), 40'd0);
        check("b2b_idle", bus.wr_ready, 1);
        @(posedge clk); #1;

        // Reset during byte 1 of word at 0x10
        d0 = done_cnt;
        exp_q.push_back({32'h10, 8'h11});
        exp_q.push_back({32'h11, 8'h22});
        drive_req(32'h10, 32'h4433_2211, 4'hF);
        @(posedge clk); #1;   // edge N
        idle_inputs();
        @(posedge clk); #1;   // cycle N+2 writes byte 1
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_we", bus.mem_we, 0);
        check("rst_mid_ready", bus.wr_ready, 1);
        check("rst_mid_busy", bus.busy, 0);
        repeat (4) @(negedge clk);
        check("rst_mid_no_done", 40'(done_cnt - d0), 40'd0);
        check("rst_mid_bytes", 40'(exp_q.size()), 40'd0);
        @(posedge clk); #1;

        // reset and wr_valid together: reset wins
        reset = 1'b1;
        drive_req(32'h0, 32'h7777_7777, 4'hF);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rst_valid_busy", bus.busy, 0);
        check("rst_valid_state", dbg_state, 0);
        check("rst_valid_addr", bus.mem_addr, 0);
        repeat (5) @(negedge clk);
        check("rst_valid_bytes", 40'(exp_q.size()), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
